// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result capture path.
package alu_pkg;

  localparam int RES_W    = 5;
  localparam int SAMPLE_W = 6;

  typedef struct packed {
    logic             gt_zero;
    logic [RES_W-1:0] result;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } cap_state_e;

  function automatic logic [RES_W-1:0] res_max(input logic [RES_W-1:0] a,
                                                input logic [RES_W-1:0] b);
    logic [RES_W-1:0] m;
    if (b > a) begin
      m = b;
    end else begin
      m = a;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_result_capture_if.sv
// Capture-side control, sample input and readout port bundle.
interface alu_result_capture_if
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic                start;
  logic [RES_W-1:0]    result;
  logic                gt_zero;
  logic                out_ready;
  logic                out_valid;
  logic [SAMPLE_W-1:0] out_data;
  logic                busy;
  logic [CNT_W-1:0]    pos_count;
  logic                overflow;
  logic [RES_W-1:0]    max_result;

  modport master (
    output start, result, gt_zero, out_ready,
    input  out_valid, out_data, busy, pos_count, overflow, max_result
  );

  modport slave (
    input  start, result, gt_zero, out_ready,
    output out_valid, out_data, busy, pos_count, overflow, max_result
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop_ok_s  = pop & (count_r != (AW+1)'(0));
  assign push_ok_s = push & ((count_r < (AW+1)'(DEPTH)) | pop_ok_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == (AW+1)'(0));
  assign count = count_r;

endmodule

// File: rtl/alu_result_capture.sv
// Captures {gt_zero, result} over a fixed window into a FIFO and keeps statistics.
// Optional feature macro: RESULT_MAX_EN (tracks the largest accepted result).
module alu_result_capture
  import alu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int N_SAMPLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_result_capture_if.slave   cap
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SCW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

  cap_state_e       state_r;
  cap_state_e       state_s;
  logic [SCW-1:0]   sample_cnt_r;
  logic [CNT_W-1:0] pos_count_r;
  logic             overflow_r;

  sample_t          in_sample_s;
  logic [SAMPLE_W-1:0] head_s;
  logic             full_s;
  logic             empty_s;
  logic [AW:0]      count_s;
  logic             capture_s;
  logic             clear_s;
  logic             last_s;
  logic             pop_s;
  logic             push_acc_s;

  assign in_sample_s = '{gt_zero: cap.gt_zero, result: cap.result};
  assign capture_s   = (state_r == CAPTURE);
  assign clear_s     = (state_r == IDLE) & cap.start;
  assign last_s      = (sample_cnt_r == SCW'(N_SAMPLES - 1));
  assign pop_s       = ~empty_s & cap.out_ready;
  assign push_acc_s  = capture_s & (~full_s | pop_s);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_acc_s),
    .pop   (pop_s),
    .wdata (in_sample_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture FSM next-state logic; start only matters in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cap.start) begin
          state_s = CAPTURE;
        end else begin
          state_s = IDLE;
        end
      end
      CAPTURE: begin
        if (last_s) begin
          state_s = DRAIN;
        end else begin
          state_s = CAPTURE;
        end
      end
      DRAIN: begin
        if (count_s == (AW+1)'(0)) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Window counter and statistics; dropped samples still advance the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt_r <= {SCW{1'b0}};
      pos_count_r  <= {CNT_W{1'b0}};
      overflow_r   <= 1'b0;
    end else if (clear_s) begin
      sample_cnt_r <= {SCW{1'b0}};
      pos_count_r  <= {CNT_W{1'b0}};
      overflow_r   <= 1'b0;
    end else if (capture_s) begin
      sample_cnt_r <= sample_cnt_r + SCW'(1);
      if (push_acc_s) begin
        if (cap.gt_zero && (pos_count_r != {CNT_W{1'b1}})) begin
          pos_count_r <= pos_count_r + CNT_W'(1);
        end
      end else begin
        overflow_r <= 1'b1;
      end
    end
  end

`ifdef RESULT_MAX_EN
  logic [RES_W-1:0] max_result_r;

  // Running unsigned maximum of accepted results.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_result_r <= {RES_W{1'b0}};
    end else if (clear_s) begin
      max_result_r <= {RES_W{1'b0}};
    end else if (push_acc_s) begin
      max_result_r <= res_max(max_result_r, cap.result);
    end
  end

  assign cap.max_result = max_result_r;
`else
  assign cap.max_result = 5'd0;
`endif

  assign cap.out_valid = ~empty_s;
  assign cap.out_data  = head_s;
  assign cap.busy      = (state_r != IDLE);
  assign cap.pos_count = pos_count_r;
  assign cap.overflow  = overflow_r;

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed self-checking bench for alu_result_capture (DEPTH=8, N_SAMPLES=16, CNT_W=8).
module tb_alu_result_capture;

  logic clk;
  logic reset;

`ifdef RESULT_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  alu_result_capture_if #(.CNT_W(8)) cap_if ();

  alu_result_capture #(
    .DEPTH     (8),
    .N_SAMPLES (16),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cap   (cap_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0] popped_q [$];
  logic [5:0] exp_q    [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every handshake the consumer completes.
  always @(posedge clk) begin
    if (!reset && cap_if.out_valid && cap_if.out_ready) begin
      popped_q.push_back(cap_if.out_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_window();
    cap_if.start = 1'b1;
    step();
    cap_if.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (cap_if.busy && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, cap_if.busy, 0);
  endtask

  task automatic check_pops(input string tag);
    int n;
    check_eq({tag, "_npops"}, popped_q.size(), exp_q.size());
    n = (popped_q.size() < exp_q.size()) ? popped_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_pop%0d", tag, i), popped_q[i], exp_q[i]);
    end
    popped_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [4:0] r;
    int nz;

    reset          = 1'b1;
    cap_if.start   = 1'b0;
    cap_if.result  = 5'd0;
    cap_if.gt_zero = 1'b0;
    cap_if.out_ready = 1'b0;
    step();
    step();
    check_eq("rst_valid", cap_if.out_valid, 0);
    check_eq("rst_busy", cap_if.busy, 0);
    check_eq("rst_pos", cap_if.pos_count, 0);
    check_eq("rst_ovf", cap_if.overflow, 0);
    check_eq("rst_max", cap_if.max_result, 0);
    reset = 1'b0;
    step();

    // T1: streaming 1..16 with the consumer always ready
    popped_q.delete();
    cap_if.out_ready = 1'b1;
    start_window();
    for (int i = 0; i < 16; i++) begin
      cap_if.result  = 5'(i + 1);
      cap_if.gt_zero = 1'b1;
      exp_q.push_back({1'b1, 5'(i + 1)});
      step();
      if (i == 0) begin
        check_eq("t1_lat_valid", cap_if.out_valid, 1);
        check_eq("t1_lat_data", cap_if.out_data, 6'h21);
      end
    end
    cap_if.gt_zero = 1'b0;
    cap_if.result  = 5'd0;
    check_eq("t1_busy_drain", cap_if.busy, 1);
    step();
    check_eq("t1_empty_after_last", cap_if.out_valid, 0);
    check_eq("t1_busy_cnt0", cap_if.busy, 1);
    step();
    check_eq("t1_busy_low", cap_if.busy, 0);
    check_eq("t1_pos", cap_if.pos_count, 16);
    check_eq("t1_ovf", cap_if.overflow, 0);
    check_eq("t1_max", cap_if.max_result, MAX_EN ? 16 : 0);
    check_pops("t1");

    // T2: consumer stalled through the whole window
    cap_if.out_ready = 1'b0;
    start_window();
    for (int i = 0; i < 16; i++) begin
      cap_if.result  = 5'(i + 1);
      cap_if.gt_zero = 1'b1;
      if (i < 8) exp_q.push_back({1'b1, 5'(i + 1)});
      step();
      if (i == 7) check_eq("t2_ovf_8th", cap_if.overflow, 0);
      if (i == 8) check_eq("t2_ovf_9th", cap_if.overflow, 1);
    end
    check_eq("t2_pos", cap_if.pos_count, 8);
    check_eq("t2_max", cap_if.max_result, MAX_EN ? 8 : 0);
    cap_if.out_ready = 1'b1;
    wait_idle(20, "t2_idle");
    check_eq("t2_ovf_sticky", cap_if.overflow, 1);
    check_pops("t2");

    // T3: full FIFO popped and pushed in the same cycle
    cap_if.out_ready = 1'b0;
    start_window();
    for (int i = 0; i < 16; i++) begin
      cap_if.out_ready = (i >= 8);
      cap_if.result    = 5'(i + 10);
      cap_if.gt_zero   = 1'b1;
      exp_q.push_back({1'b1, 5'(i + 10)});
      step();
    end
    check_eq("t3_ovf", cap_if.overflow, 0);
    check_eq("t3_pos", cap_if.pos_count, 16);
    check_eq("t3_max", cap_if.max_result, MAX_EN ? 25 : 0);
    wait_idle(20, "t3_idle");
    check_pops("t3");

    // T4: zero/nonzero mix with stray start pulses mid-window
    cap_if.out_ready = 1'b1;
    nz = 0;
    start_window();
    for (int i = 0; i < 16; i++) begin
      r = (i % 3 == 0) ? 5'd0 : 5'(i);
      cap_if.result  = r;
      cap_if.gt_zero = (r != 5'd0);
      cap_if.start   = (i == 5 || i == 6);
      if (r != 5'd0) nz++;
      exp_q.push_back({(r != 5'd0), r});
      step();
    end
    cap_if.start   = 1'b0;
    cap_if.result  = 5'd9;
    cap_if.gt_zero = 1'b1;
    wait_idle(20, "t4_idle");
    check_eq("t4_pos", cap_if.pos_count, nz);
    check_eq("t4_max", cap_if.max_result, MAX_EN ? 14 : 0);
    check_pops("t4");

    // T6: maximum tracking over 3, 31, 7
    cap_if.out_ready = 1'b1;
    start_window();
    for (int i = 0; i < 16; i++) begin
      r = (i == 0) ? 5'd3 : (i == 1) ? 5'd31 : (i == 2) ? 5'd7 : 5'd0;
      cap_if.result  = r;
      cap_if.gt_zero = (r != 5'd0);
      step();
    end
    wait_idle(20, "t6_idle");
    check_eq("t6_max", cap_if.max_result, MAX_EN ? 31 : 0);
    check_eq("t6_pos", cap_if.pos_count, 3);
    popped_q.delete();

    // T5: reset while five samples are buffered mid-window
    cap_if.out_ready = 1'b0;
    start_window();
    for (int i = 0; i < 5; i++) begin
      cap_if.result  = 5'(i + 1);
      cap_if.gt_zero = 1'b1;
      step();
    end
    check_eq("t5_pre_pos", cap_if.pos_count, 5);
    check_eq("t5_pre_valid", cap_if.out_valid, 1);
    reset = 1'b1;
    step();
    check_eq("t5_valid", cap_if.out_valid, 0);
    check_eq("t5_busy", cap_if.busy, 0);
    check_eq("t5_pos", cap_if.pos_count, 0);
    check_eq("t5_ovf", cap_if.overflow, 0);
    check_eq("t5_max", cap_if.max_result, 0);
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
